tof_i2c_arbiter: RTL and testbench
==================================

Name: tof_i2c_arbiter

Overview:
- Shares one I2C master engine between NUM_REQ ToF sensor drivers.
- Round-robin arbitration; latches the winner's transaction descriptor, pulses the engine start, routes byte handshakes and data to the grantee, and detects completion or timeout.
- Sits between the per-sensor ToF driver FSMs and the single I2C engine plus its pad tristate logic.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT_CYCLES, 1048576, max clock cycles in WAIT_DONE before abort (must be >= 2)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
req  in  NUM_REQ  per-requester transaction request (level)
req_slave_addr  in  7*NUM_REQ  slave address, requester i at [7i+6:7i]
req_reg_addr  in  16*NUM_REQ  register address, requester i at [16i+15:16i]
req_is_read  in  NUM_REQ  1=read, 0=write
req_nb_bytes  in  17*NUM_REQ  byte count field, passed to engine unchanged
req_wdata  in  8*NUM_REQ  write byte, requester i at [8i+7:8i]
gnt  out  NUM_REQ  one-hot grant
done  out  NUM_REQ  1-cycle completion pulse to grantee
err  out  NUM_REQ  1-cycle timeout/engine-error pulse to grantee
byte_ready  out  NUM_REQ  engine byte strobe routed to grantee only
rdata  out  8  engine read byte (shared)
eng_start  out  1  1-cycle start to engine
eng_slave_addr  out  7  latched descriptor
eng_reg_addr  out  16  latched descriptor
eng_is_read  out  1  latched descriptor
eng_nb_bytes  out  17  latched descriptor
eng_wdata  out  8  live mux of grantee's req_wdata
eng_abort  out  1  1-cycle engine reset request
eng_ready  in  1  engine per-byte strobe
eng_done  in  1  engine end-of-transaction pulse
eng_error  in  1  engine error flag
eng_rdata  in  8  engine read byte

Behaviour:
- Reset (reset==0 at posedge clock):
  - All outputs 0, state IDLE.
  - Priority pointer = 0; timeout counter = 0; descriptor registers = 0.
- States:
  - IDLE: if any req bit is set, select the first requester at or after the pointer, wrapping modulo NUM_REQ. Latch its descriptor fields and grant index; set gnt one-hot. Go to START. If no req, stay.
  - START: eng_start=1 for exactly this cycle. Clear the timeout counter. Go to WAIT_DONE.
  - WAIT_DONE: increment the timeout counter each cycle.
    - eng_done=1: done[g]=1 next cycle, go to RELEASE.
    - Else eng_error=1: err[g]=1 next cycle, go to RELEASE.
    - Else counter reaches TIMEOUT_CYCLES-1: eng_abort=1 and err[g]=1 next cycle, go to RELEASE.
    - If eng_done and eng_error are both high in the same cycle: done wins, err is not pulsed.
  - RELEASE: gnt=0; done/err/eng_abort are high during this cycle only. Pointer = (g+1) mod NUM_REQ. Go to IDLE.
- Latency: req rises at cycle 0 in IDLE → gnt at cycle 1 → eng_start at cycle 2. After eng_done, the next grant is possible 2 cycles later (RELEASE, then IDLE).
- Routing:
  - byte_ready[g] = eng_ready, registered one cycle, only while gnt is set; other bits stay 0.
  - rdata is registered from eng_rdata on eng_ready.
  - eng_wdata is combinational from req_wdata[g] so the requester can update it on byte_ready.
- Descriptor stability: fields are sampled once in IDLE. Later changes to req_* fields are ignored until the next grant.
- Requester dropping req mid-transaction: ignored. The transaction runs to done/err; the pulse is still issued.
- A requester holding req after done is re-eligible, but only after other pending requesters per round-robin. No back-to-back starvation.
- eng_ready/eng_done outside WAIT_DONE: ignored, no output effect.
- Reset mid-transaction: immediate return to IDLE with all outputs 0. No done/err pulse. eng_abort is not asserted; the engine shares the reset.

Test Plan:
- Single requester: req[1]=1, slave 0x29, reg 0x0010, read, nb 0 → gnt=0b0010 at cycle 1, eng_start at cycle 2 with eng_slave_addr=0x29, eng_reg_addr=0x0010. eng_done 10 cycles later → done[1] pulse, gnt=0.
- Round-robin: req=0b1111 held, eng_done returned 5 cycles after each start → grant order 0,1,2,3,0; no index granted twice in a row.
- Write routing: grantee 2, eng_ready pulses 3 times → byte_ready[2] pulses 3 times one cycle later, other bits 0. eng_wdata tracks req_wdata[23:16] as it changes.
- Timeout: TIMEOUT_CYCLES=16, eng_done never asserted → eng_abort and err[g] pulse together 16 cycles after start, then the next requester is granted.
- Collision: eng_done and eng_error high in the same cycle → done[g]=1, err=0. eng_error alone → err[g]=1, done=0.
- Reset mid-WAIT_DONE: reset=0 for one cycle → all outputs 0 next cycle, pointer=0; pending req=0b0100 → gnt=0b0100 two cycles after reset releases.

Source files
------------

// File: rtl/tof_i2c_arbiter.sv
// rtl/tof_i2c_arbiter.sv - round-robin arbiter sharing one I2C engine between ToF sensor drivers
// Latches the winner's descriptor, starts the engine, routes byte strobes and reports done/err.
module tof_i2c_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [7*NUM_REQ-1:0]    req_slave_addr,
    input  logic [16*NUM_REQ-1:0]   req_reg_addr,
    input  logic [NUM_REQ-1:0]      req_is_read,
    input  logic [17*NUM_REQ-1:0]   req_nb_bytes,
    input  logic [8*NUM_REQ-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]      gnt,
    output logic [NUM_REQ-1:0]      done,
    output logic [NUM_REQ-1:0]      err,
    output logic [NUM_REQ-1:0]      byte_ready,
    output logic [7:0]              rdata,
    output logic                    eng_start,
    output logic [6:0]              eng_slave_addr,
    output logic [15:0]             eng_reg_addr,
    output logic                    eng_is_read,
    output logic [16:0]             eng_nb_bytes,
    output logic [7:0]              eng_wdata,
    output logic                    eng_abort,
    input  logic                    eng_ready,
    input  logic                    eng_done,
    input  logic                    eng_error,
    input  logic [7:0]              eng_rdata
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_REQ - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_START   = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      g_q, g_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [6:0]         slave_q, slave_d;
    logic [15:0]        reg_q, reg_d;
    logic               is_read_q, is_read_d;
    logic [16:0]        nb_q, nb_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               start_q, start_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [NUM_REQ-1:0] err_q, err_d;
    logic               abort_q, abort_d;
    logic [NUM_REQ-1:0] bready_q, bready_d;
    logic [7:0]         rdata_q, rdata_d;

    logic [IW-1:0]      sel_idx;
    logic [IW:0]        cand;
    logic [NUM_REQ-1:0] sel_onehot;
    logic [6:0]         sel_slave;
    logic [15:0]        sel_reg;
    logic               sel_is_read;
    logic [16:0]        sel_nb;

    // Scan downwards so the smallest offset from the pointer wins.
    always_comb begin
        sel_idx = ptr_q;
        cand    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = {1'b0, ptr_q} + (IW+1)'(i);
            if (cand >= (IW+1)'(NUM_REQ)) begin
                cand = cand - (IW+1)'(NUM_REQ);
            end
            if (req[cand[IW-1:0]]) begin
                sel_idx = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        sel_onehot  = '0;
        sel_slave   = '0;
        sel_reg     = '0;
        sel_is_read = 1'b0;
        sel_nb      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel_idx == IW'(i)) begin
                sel_onehot[i] = 1'b1;
                sel_slave     = req_slave_addr[i*7 +: 7];
                sel_reg       = req_reg_addr[i*16 +: 16];
                sel_is_read   = req_is_read[i];
                sel_nb        = req_nb_bytes[i*17 +: 17];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        g_d       = g_q;
        gnt_d     = gnt_q;
        slave_d   = slave_q;
        reg_d     = reg_q;
        is_read_d = is_read_q;
        nb_d      = nb_q;
        cnt_d     = cnt_q;
        start_d   = 1'b0;
        done_d    = '0;
        err_d     = '0;
        abort_d   = 1'b0;
        bready_d  = '0;
        rdata_d   = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    g_d       = sel_idx;
                    gnt_d     = sel_onehot;
                    slave_d   = sel_slave;
                    reg_d     = sel_reg;
                    is_read_d = sel_is_read;
                    nb_d      = sel_nb;
                    state_d   = S_START;
                end
            end
            S_START: begin
                start_d = 1'b1;
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (eng_ready) begin
                    bready_d = gnt_q;
                    rdata_d  = eng_rdata;
                end
                // done has priority over a simultaneous error
                if (eng_done) begin
                    done_d  = gnt_q;
                    gnt_d   = '0;
                    state_d = S_RELEASE;
                end else if (eng_error) begin
                    err_d   = gnt_q;
                    gnt_d   = '0;
                    state_d = S_RELEASE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = gnt_q;
                    abort_d = 1'b1;
                    gnt_d   = '0;
                    state_d = S_RELEASE;
                end
            end
            default: begin
                ptr_d   = (g_q == IDX_LAST) ? '0 : g_q + 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            g_q       <= '0;
            gnt_q     <= '0;
            slave_q   <= '0;
            reg_q     <= '0;
            is_read_q <= 1'b0;
            nb_q      <= '0;
            cnt_q     <= '0;
            start_q   <= 1'b0;
            done_q    <= '0;
            err_q     <= '0;
            abort_q   <= 1'b0;
            bready_q  <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            g_q       <= g_d;
            gnt_q     <= gnt_d;
            slave_q   <= slave_d;
            reg_q     <= reg_d;
            is_read_q <= is_read_d;
            nb_q      <= nb_d;
            cnt_q     <= cnt_d;
            start_q   <= start_d;
            done_q    <= done_d;
            err_q     <= err_d;
            abort_q   <= abort_d;
            bready_q  <= bready_d;
            rdata_q   <= rdata_d;
        end
    end

    // Write byte follows the grantee live so it can advance on each byte_ready.
    always_comb begin
        eng_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_q[i]) begin
                eng_wdata = req_wdata[i*8 +: 8];
            end
        end
    end

    assign gnt            = gnt_q;
    assign done           = done_q;
    assign err            = err_q;
    assign byte_ready     = bready_q;
    assign rdata          = rdata_q;
    assign eng_start      = start_q;
    assign eng_slave_addr = slave_q;
    assign eng_reg_addr   = reg_q;
    assign eng_is_read    = is_read_q;
    assign eng_nb_bytes   = nb_q;
    assign eng_abort      = abort_q;

endmodule

// File: tb/tb_tof_i2c_arbiter.sv
// tb/tb_tof_i2c_arbiter.sv - scoreboard bench for tof_i2c_arbiter
module tb_tof_i2c_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    localparam int K_START = 1;
    localparam int K_END   = 2;
    localparam int K_GNT   = 3;
    localparam int K_BYTE  = 4;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [N-1:0]    req = '0;
    logic [7*N-1:0]  req_slave_addr = '0;
    logic [16*N-1:0] req_reg_addr = '0;
    logic [N-1:0]    req_is_read = '0;
    logic [17*N-1:0] req_nb_bytes = '0;
    logic [8*N-1:0]  req_wdata = '0;
    logic [N-1:0]    gnt, done, err, byte_ready;
    logic [7:0]      rdata;
    logic            eng_start;
    logic [6:0]      eng_slave_addr;
    logic [15:0]     eng_reg_addr;
    logic            eng_is_read;
    logic [16:0]     eng_nb_bytes;
    logic [7:0]      eng_wdata;
    logic            eng_abort;
    logic            eng_ready = 1'b0;
    logic            eng_done = 1'b0;
    logic            eng_error = 1'b0;
    logic [7:0]      eng_rdata = '0;

    tof_i2c_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset), .req(req),
        .req_slave_addr(req_slave_addr), .req_reg_addr(req_reg_addr),
        .req_is_read(req_is_read), .req_nb_bytes(req_nb_bytes), .req_wdata(req_wdata),
        .gnt(gnt), .done(done), .err(err), .byte_ready(byte_ready), .rdata(rdata),
        .eng_start(eng_start), .eng_slave_addr(eng_slave_addr), .eng_reg_addr(eng_reg_addr),
        .eng_is_read(eng_is_read), .eng_nb_bytes(eng_nb_bytes), .eng_wdata(eng_wdata),
        .eng_abort(eng_abort), .eng_ready(eng_ready), .eng_done(eng_done),
        .eng_error(eng_error), .eng_rdata(eng_rdata)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          kind;
        int          cyc;
        logic [63:0] val;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;
    logic [N-1:0] prev_gnt = '0;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    function automatic logic [40:0] dsc(input int i);
        logic [6:0]  s;
        logic [15:0] r;
        logic        rd;
        logic [16:0] nb;
        s  = 7'(48 + i);
        r  = 16'(40960 + 273 * i);
        rd = (i % 2) == 1;
        nb = 17'(65536 + i);
        return {s, r, rd, nb};
    endfunction

    function automatic logic [63:0] start_val(input logic [N-1:0] oh, input int i);
        return 64'({oh, dsc(i)});
    endfunction

    function automatic logic [63:0] end_val(input logic [N-1:0] d, input logic [N-1:0] e,
                                             input logic a);
        return 64'({d, e, a, 4'b0000});
    endfunction

    task automatic expect_ev(input int kind, input int at, input logic [63:0] val,
                             input string name);
        exp_t e;
        e.kind = kind;
        e.cyc  = at;
        e.val  = val;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic wait_until(input int at);
        while (cyc < at) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset;
        reset = 1'b0;
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b1;
    endtask

    task automatic load_desc;
        for (int i = 0; i < N; i++) begin
            logic [40:0] d;
            d = dsc(i);
            req_slave_addr[i*7 +: 7]  = d[40:34];
            req_reg_addr[i*16 +: 16]  = d[33:18];
            req_is_read[i]            = d[17];
            req_nb_bytes[i*17 +: 17]  = d[16:0];
        end
    endtask

    // Monitor: every cycle with visible DUT activity is matched against the next expectation.
    initial begin
        int          k;
        logic [63:0] v;
        exp_t        e;
        forever begin
            @(negedge clock);
            if (mon_en) begin
                k = 0;
                v = '0;
                if (eng_start) begin
                    k = K_START;
                    v = 64'({gnt, eng_slave_addr, eng_reg_addr, eng_is_read, eng_nb_bytes});
                end else if ((|done) || (|err) || eng_abort) begin
                    k = K_END;
                    v = 64'({done, err, eng_abort, gnt});
                end else if (gnt !== prev_gnt) begin
                    k = K_GNT;
                    v = 64'(gnt);
                end else if (|byte_ready) begin
                    k = K_BYTE;
                    v = 64'({byte_ready, rdata, eng_wdata});
                end
                if (k != 0) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_event: kind %0d cycle %0d got %h, required none",
                                 k, cyc, v);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.kind != k || e.cyc != cyc || e.val !== v) begin
                            n_fail++;
                            $display("FAIL %s: got kind %0d cycle %0d value %h, required kind %0d cycle %0d value %h",
                                     e.name, k, cyc, v, e.kind, e.cyc, e.val);
                        end
                    end
                end
                prev_gnt = gnt;
            end
        end
    end

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        int c0, s, c1;
        logic [7:0] bdat [3];
        bdat[0] = 8'h11;
        bdat[1] = 8'h22;
        bdat[2] = 8'h33;

        req_wdata = 32'hDEADBEEF;
        reset = 1'b0;
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        n_checks++;
        if ({gnt, done, err, byte_ready, rdata, eng_start, eng_slave_addr, eng_reg_addr,
             eng_is_read, eng_nb_bytes, eng_wdata, eng_abort} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: gnt %b done %b err %b eng_start %b eng_wdata %h, required all 0",
                     gnt, done, err, eng_start, eng_wdata);
        end
        reset = 1'b1;
        prev_gnt = '0;
        mon_en = 1'b1;

        // Single requester, read, engine done 10 cycles after start
        load_desc();
        req_slave_addr[13:7]  = 7'h29;
        req_reg_addr[31:16]   = 16'h0010;
        req_is_read[1]        = 1'b1;
        req_nb_bytes[33:17]   = 17'h0;
        c0 = cyc;
        s  = c0 + 2;
        expect_ev(K_GNT, c0 + 1, 64'(4'b0010), "single_gnt");
        expect_ev(K_START, s, 64'({4'b0010, 7'h29, 16'h0010, 1'b1, 17'h0}), "single_start");
        expect_ev(K_END, s + 11, end_val(4'b0010, 4'b0000, 1'b0), "single_done");
        req = 4'b0010;
        wait_until(c0 + 3);
        req = '0;
        wait_until(s + 10);
        eng_done = 1'b1;
        wait_until(s + 11);
        eng_done = 1'b0;
        // Engine strobes while idle must have no effect
        wait_until(s + 14);
        eng_ready = 1'b1;
        eng_rdata = 8'h77;
        eng_done  = 1'b1;
        eng_error = 1'b1;
        wait_until(s + 15);
        eng_ready = 1'b0;
        eng_done  = 1'b0;
        eng_error = 1'b0;
        wait_until(s + 18);

        // Round robin with all four requesting
        do_reset();
        load_desc();
        c0 = cyc;
        for (int k = 0; k < 5; k++) begin
            int g;
            g = c0 + 1 + 9 * k;
            expect_ev(K_GNT, g, 64'(4'b0001 << (k % 4)), "rr_gnt");
            expect_ev(K_START, g + 1, start_val(4'b0001 << (k % 4), k % 4), "rr_start");
            expect_ev(K_END, g + 7, end_val(4'b0001 << (k % 4), 4'b0000, 1'b0), "rr_done");
        end
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            int g;
            g = c0 + 1 + 9 * k;
            if (k == 4) begin
                wait_until(g + 1);
                req = '0;
            end
            wait_until(g + 6);
            eng_done = 1'b1;
            wait_until(g + 7);
            eng_done = 1'b0;
        end
        wait_until(cyc + 4);

        // Write routing to requester 2
        do_reset();
        load_desc();
        req_wdata = {8'h55, 8'hA0, 8'h66, 8'h77};
        c0 = cyc;
        s  = c0 + 2;
        expect_ev(K_GNT, c0 + 1, 64'(4'b0100), "wr_gnt");
        expect_ev(K_START, s, start_val(4'b0100, 2), "wr_start");
        for (int k = 0; k < 3; k++) begin
            expect_ev(K_BYTE, s + 3 + 2 * k, 64'({4'b0100, bdat[k], 8'(8'hA1 + k)}), "wr_byte");
        end
        expect_ev(K_END, s + 9, end_val(4'b0100, 4'b0000, 1'b0), "wr_done");
        req = 4'b0100;
        wait_until(s + 1);
        req = '0;
        for (int k = 0; k < 3; k++) begin
            wait_until(s + 2 + 2 * k);
            eng_ready = 1'b1;
            eng_rdata = bdat[k];
            wait_until(s + 3 + 2 * k);
            eng_ready = 1'b0;
            eng_rdata = 8'hEE;
            req_wdata[23:16] = 8'(8'hA1 + k);
        end
        wait_until(s + 8);
        eng_done = 1'b1;
        wait_until(s + 9);
        eng_done = 1'b0;
        wait_until(cyc + 4);

        // Timeout on requester 0, then requester 1 ends with an engine error
        do_reset();
        load_desc();
        c0 = cyc;
        s  = c0 + 2;
        expect_ev(K_GNT, c0 + 1, 64'(4'b0001), "to_gnt");
        expect_ev(K_START, s, start_val(4'b0001, 0), "to_start");
        expect_ev(K_END, s + 16, end_val(4'b0000, 4'b0001, 1'b1), "to_abort");
        expect_ev(K_GNT, s + 18, 64'(4'b0010), "to_next_gnt");
        expect_ev(K_START, s + 19, start_val(4'b0010, 1), "to_next_start");
        expect_ev(K_END, s + 22, end_val(4'b0000, 4'b0010, 1'b0), "err_only");
        req = 4'b0011;
        wait_until(s + 1);
        req = 4'b0010;
        wait_until(s + 18);
        req = '0;
        wait_until(s + 21);
        eng_error = 1'b1;
        wait_until(s + 22);
        eng_error = 1'b0;
        wait_until(cyc + 4);

        // eng_done and eng_error together: done wins
        do_reset();
        load_desc();
        c0 = cyc;
        s  = c0 + 2;
        expect_ev(K_GNT, c0 + 1, 64'(4'b1000), "coll_gnt");
        expect_ev(K_START, s, start_val(4'b1000, 3), "coll_start");
        expect_ev(K_END, s + 3, end_val(4'b1000, 4'b0000, 1'b0), "coll_done");
        req = 4'b1000;
        wait_until(s + 1);
        req = '0;
        wait_until(s + 2);
        eng_done  = 1'b1;
        eng_error = 1'b1;
        wait_until(s + 3);
        eng_done  = 1'b0;
        eng_error = 1'b0;
        wait_until(cyc + 4);

        // Reset in WAIT_DONE clears outputs and the pointer
        do_reset();
        load_desc();
        c0 = cyc;
        expect_ev(K_GNT, c0 + 1, 64'(4'b0010), "rst_pre_gnt");
        expect_ev(K_START, c0 + 2, start_val(4'b0010, 1), "rst_pre_start");
        expect_ev(K_END, c0 + 5, end_val(4'b0010, 4'b0000, 1'b0), "rst_pre_done");
        c1 = c0 + 6;
        expect_ev(K_GNT, c1 + 1, 64'(4'b0010), "rst_gnt");
        expect_ev(K_START, c1 + 2, start_val(4'b0010, 1), "rst_start");
        expect_ev(K_GNT, c1 + 5, 64'(4'b0000), "rst_clear");
        expect_ev(K_GNT, c1 + 6, 64'(4'b0001), "rst_ptr_gnt");
        expect_ev(K_START, c1 + 7, start_val(4'b0001, 0), "rst_ptr_start");
        expect_ev(K_END, c1 + 10, end_val(4'b0001, 4'b0000, 1'b0), "rst_ptr_done");
        req = 4'b0010;
        wait_until(c0 + 3);
        req = '0;
        wait_until(c0 + 4);
        eng_done = 1'b1;
        wait_until(c0 + 5);
        eng_done = 1'b0;
        wait_until(c1);
        req = 4'b0010;
        wait_until(c1 + 4);
        reset = 1'b0;
        req   = 4'b0101;
        wait_until(c1 + 5);
        reset = 1'b1;
        wait_until(c1 + 8);
        req = '0;
        wait_until(c1 + 9);
        eng_done = 1'b1;
        wait_until(c1 + 10);
        eng_done = 1'b0;
        wait_until(cyc + 5);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_events: %0d expected events never seen, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
